// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the FFT output reorder buffer: bit-reversed input side,
// natural-order output side with index and end-of-frame marker.
interface fft_bitrev_reorder_if #(
    parameter int N_bit = 16,
    parameter int LOG2N = 4
);
    logic             in_vld;
    logic             in_rdy;
    logic [N_bit-1:0] in_re;
    logic [N_bit-1:0] in_im;
    logic             out_vld;
    logic             out_rdy;
    logic [N_bit-1:0] out_re;
    logic [N_bit-1:0] out_im;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;

    // Producer of input samples / consumer of reordered samples
    modport master (
        output in_vld, in_re, in_im, out_rdy,
        input  in_rdy, out_vld, out_re, out_im, out_idx, out_last
    );

    // The reorder buffer itself
    modport slave (
        input  in_vld, in_re, in_im, out_rdy,
        output in_rdy, out_vld, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes a frame at bit-reversed addresses while the
// other bank is read out sequentially, so the output comes out in natural order.
module fft_bitrev_reorder #(
    parameter int N_bit = 16,
    parameter int N_PT  = 16,
    parameter int LOG2N = 4
) (
    input  logic                clk,
    input  logic                rst,
    fft_bitrev_reorder_if.slave bus
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_PT - 1);

    typedef logic [2*N_bit-1:0] word_t;

    word_t            mem_q [2][N_PT];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             out_vld_q, out_vld_d;
    logic [N_bit-1:0] out_re_q, out_re_d;
    logic [N_bit-1:0] out_im_q, out_im_d;
    logic [LOG2N-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             in_rdy, wr_fire, ld;
    word_t            rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // Ready depends only on registered state so the sink-side timing is clean
    assign in_rdy  = !full_q[wr_bank_q];
    assign wr_fire = bus.in_vld & in_rdy;
    assign ld      = (!out_vld_q | bus.out_rdy) & full_q[rd_bank_q];
    assign rd_word = mem_q[rd_bank_q][rd_cnt_q];

    assign bus.in_rdy   = in_rdy;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_re   = out_re_q;
    assign bus.out_im   = out_im_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.out_last = out_last_q;

    // Next-state for write/read pointers, bank flags and the output register.
    // Writer and reader never touch the same bank's flag on one edge: the
    // writer only targets an empty bank, the reader only a full one.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;
        full_d     = full_q;
        out_vld_d  = out_vld_q;
        out_re_d   = out_re_q;
        out_im_d   = out_im_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (ld) begin
            out_vld_d  = 1'b1;
            out_re_d   = rd_word[2*N_bit-1:N_bit];
            out_im_d   = rd_word[N_bit-1:0];
            out_idx_d  = rd_cnt_q;
            out_last_d = (rd_cnt_q == LAST);
            rd_cnt_d   = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_vld_q & bus.out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            full_q     <= '0;
            out_vld_q  <= 1'b0;
            out_re_q   <= '0;
            out_im_q   <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
            full_q     <= full_d;
            out_vld_q  <= out_vld_d;
            out_re_q   <= out_re_d;
            out_im_q   <= out_im_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    // Sample storage: scatter arrivals to their bit-reversed slot; no reset
    always_ff @(posedge clk) begin
        if (rst && wr_fire)
            mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= {bus.in_re, bus.in_im};
    end
endmodule
